// File: rtl/pwm_bcd_converter_if.sv
// Request/result bundle between the PWM measurement source and the BCD converter.
interface pwm_bcd_converter_if #(
  parameter int unsigned W = 14
);
  logic         start;
  logic [W-1:0] value;
  logic         busy;
  logic         done;
  logic         ovf;
  logic [3:0]   dig0;
  logic [3:0]   dig1;
  logic [3:0]   dig2;
  logic [3:0]   dig3;

  modport master (
    output start, value,
    input  busy, done, ovf, dig0, dig1, dig2, dig3
  );

  modport slave (
    input  start, value,
    output busy, done, ovf, dig0, dig1, dig2, dig3
  );
endinterface

// File: rtl/pwm_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter feeding the 4-digit display mux.
// Digits are only rewritten at the end of a conversion, so the display never sees partial results.
module pwm_bcd_converter #(
  parameter int unsigned W           = 14,
  parameter logic [3:0]  DIGITS_DASH = 4'd10
) (
  input  logic                 clock,
  input  logic                 reset,
  pwm_bcd_converter_if.slave   bus
);

  localparam int unsigned CW    = $clog2(W + 1);
  localparam int unsigned BCD_W = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_next;
  logic [CW-1:0]    cnt;
  logic             ovf_pend;
  logic             last_iter;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q;
  logic [BCD_W-1:0] dig_q;

  // Add-3 correction on every nibble that would overflow past 9 when doubled
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bcd_next  = {bcd_adj[BCD_W-2:0], bin_sr[W-1]};
  assign last_iter = (state_q == SHIFT) && (cnt == CW'(1));

  // State register plus registered status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags follow the state being entered so they line up with it
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // Datapath; the result is committed on the edge entering DONE so it appears with done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      ovf_q    <= 1'b0;
      dig_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            bin_sr   <= bus.value;
            bcd_sr   <= '0;
            cnt      <= CW'(W);
            ovf_pend <= (32'(bus.value) > 32'd9999);
          end
        end
        SHIFT: begin
          bcd_sr <= bcd_next;
          bin_sr <= bin_sr << 1;
          cnt    <= cnt - CW'(1);
          if (last_iter) begin
            dig_q <= ovf_pend ? {4{DIGITS_DASH}} : bcd_next;
            ovf_q <= ovf_pend;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.dig0 = dig_q[3:0];
  assign bus.dig1 = dig_q[7:4];
  assign bus.dig2 = dig_q[11:8];
  assign bus.dig3 = dig_q[15:12];

endmodule

// File: tb/tb_pwm_bcd_converter.sv
// Self-checking bench for pwm_bcd_converter: directed table, corner sequences, random sweep.
module tb_pwm_bcd_converter;

  localparam int unsigned W = 14;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   n_accept;
  int   n_done;

  pwm_bcd_converter_if #(.W(W)) bus ();

  pwm_bcd_converter #(.W(W), .DIGITS_DASH(4'd10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (!reset && bus.done) n_done++;

  typedef struct {
    int          value;
    logic [15:0] digits;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dig_bus();
    return {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
  endfunction

  // Reference: decimal digits by plain division, dashes above 9999
  task automatic ref_model(input int v, output logic [15:0] d, output logic o);
    if (v > 9999) begin
      d = {4'd10, 4'd10, 4'd10, 4'd10};
      o = 1'b1;
    end else begin
      d = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      o = 1'b0;
    end
  endtask

  // One conversion from IDLE: checks busy window, done cycle, results and pulse width
  task automatic convert(input int v, input logic [15:0] exp_d, input logic exp_o, input string tag);
    int bad;
    bad = 0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.value = 14'(v);
    @(negedge clock);
    n_accept++;
    bus.start = 1'b0;
    bus.value = 14'($urandom);
    for (int i = 0; i < int'(W); i++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      @(negedge clock);
    end
    check({tag, ".busy_window"}, 32'(bad), 32'd0);
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".busy_in_done"}, 32'(bus.busy), 32'd0);
    check({tag, ".digits"}, 32'(dig_bus()), 32'(exp_d));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_o));
    @(negedge clock);
    check({tag, ".done_width"}, 32'(bus.done), 32'd0);
    check({tag, ".digits_hold"}, 32'(dig_bus()), 32'(exp_d));
  endtask

  initial begin
    vec_t        vecs[11];
    logic [15:0] md;
    logic        mo;
    int          bad;
    int          v;

    n_cmp = 0; n_fail = 0; n_accept = 0; n_done = 0;
    vecs[0]  = '{0,     16'h0000, 1'b0};
    vecs[1]  = '{1234,  16'h1234, 1'b0};
    vecs[2]  = '{9999,  16'h9999, 1'b0};
    vecs[3]  = '{10000, 16'hAAAA, 1'b1};
    vecs[4]  = '{16383, 16'hAAAA, 1'b1};
    vecs[5]  = '{1,     16'h0001, 1'b0};
    vecs[6]  = '{9,     16'h0009, 1'b0};
    vecs[7]  = '{10,    16'h0010, 1'b0};
    vecs[8]  = '{99,    16'h0099, 1'b0};
    vecs[9]  = '{5000,  16'h5000, 1'b0};
    vecs[10] = '{8765,  16'h8765, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.value = '0;
    repeat (2) @(negedge clock);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.ovf", 32'(bus.ovf), 32'd0);
    check("reset.digits", 32'(dig_bus()), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      convert(vecs[i].value, vecs[i].digits, vecs[i].ovf, $sformatf("vec%0d", i));

    // Back-to-back with start held: 9999 then 10000, done pulses W+2 apart
    @(negedge clock);
    bus.start = 1'b1;
    bus.value = 14'd9999;
    @(negedge clock);
    bus.value = 14'd10000;
    repeat (W) @(negedge clock);
    check("b2b.first_done", 32'(bus.done), 32'd1);
    check("b2b.first_digits", 32'(dig_bus()), 32'h9999);
    check("b2b.first_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    check("b2b.second_busy", 32'(bus.busy), 32'd1);
    bad = 0;
    repeat (W) begin
      @(negedge clock);
      if (bus.done !== 1'b1) bad++;
    end
    check("b2b.second_done", 32'(bus.done), 32'd1);
    check("b2b.second_digits", 32'(dig_bus()), 32'hAAAA);
    check("b2b.second_ovf", 32'(bus.ovf), 32'd1);
    n_accept += 2;

    // Start mid-SHIFT is ignored and not queued
    @(negedge clock);
    bus.start = 1'b1;
    bus.value = 14'd42;
    @(negedge clock);
    n_accept++;
    bus.start = 1'b0;
    repeat (4) @(negedge clock);
    bus.start = 1'b1;
    bus.value = 14'd7777;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (W - 5) @(negedge clock);
    check("ignore.done", 32'(bus.done), 32'd1);
    check("ignore.digits", 32'(dig_bus()), 32'h0042);
    bad = 0;
    repeat (W + 2) begin
      @(negedge clock);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check("ignore.no_requeue", 32'(bad), 32'd0);
    convert(31, 16'h0031, 1'b0, "after_ignore");

    // Asynchronous reset mid-conversion
    @(negedge clock);
    bus.start = 1'b1;
    bus.value = 14'd5678;
    @(negedge clock);
    n_accept++;
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("areset.busy", 32'(bus.busy), 32'd0);
    check("areset.done", 32'(bus.done), 32'd0);
    check("areset.ovf", 32'(bus.ovf), 32'd0);
    check("areset.digits", 32'(dig_bus()), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    n_accept--;
    bad = 0;
    repeat (W + 4) begin
      @(negedge clock);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("areset.no_done", 32'(bad), 32'd0);
    convert(5678, 16'h5678, 1'b0, "after_reset");

    // Random sweep against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      v = (i % 2 == 0) ? int'($urandom_range(16383, 0)) : int'($urandom_range(9999, 0));
      ref_model(v, md, mo);
      convert(v, md, mo, $sformatf("rand%0d_v%0d", i, v));
    end

    @(negedge clock);
    check("done_count", 32'(n_done), 32'(n_accept));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_bcd_converter.md
Name: pwm_bcd_converter

Overview:
Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment multiplexer. It takes a binary measurement from the PWM core (duty count or percentage) and converts it with an iterative shift-add-3 (double dabble) loop, one bit per clock. It drives the multiplexer's four 4-bit digit inputs with stable, registered BCD codes. Values above 9999 are flagged and shown as four dash codes (4'd10).

Parameters:
W, 14, binary input width; legal range 4..14
DIGITS_DASH, 4'd10, digit code the downstream display decodes as a dash (segment g only)

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  conversion request; sampled only in IDLE
value  input  W  binary value; captured on the accepted start
busy   output 1  high while the conversion is in progress
done   output 1  one-cycle pulse; digit outputs were updated on this cycle
ovf    output 1  latched overflow flag for the most recently completed conversion
dig0   output 4  BCD units digit; feeds display input 0 (rightmost)
dig1   output 4  BCD tens digit
dig2   output 4  BCD hundreds digit
dig3   output 4  BCD thousands digit

Behaviour:
- Reset, asynchronous, active-high: state=IDLE; busy=0, done=0, ovf=0, dig0..dig3=4'd0; the scratch registers and iteration counter are cleared. A reset during SHIFT aborts the conversion. The outputs take their reset values immediately, and no done pulse follows.
- Internal registers:
  - bin_sr[W-1:0] holds the shift source.
  - bcd_sr[15:0] holds four BCD nibbles.
  - cnt is a counter of ceil(log2(W+1)) bits.
  - ovf_pend is a 1-bit flag.
- FSM has 3 states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at a clock edge: bin_sr<=value; bcd_sr<=0; cnt<=W; ovf_pend<=(value>9999); go to SHIFT.
  - If start=0: remain in IDLE.
- SHIFT, one iteration per cycle:
  - Each nibble of bcd_sr that is >=5 gets +3.
  - Then {bcd_sr,bin_sr} shifts left by 1, with the MSB of bin_sr entering bcd_sr[0].
  - cnt decrements.
  - After the iteration where cnt goes from 1 to 0, go to DONE.
- DONE, one cycle:
  - If ovf_pend=0: dig3..dig0 <= bcd_sr[15:12],[11:8],[7:4],[3:0]. If ovf_pend=1: all four digits <= DIGITS_DASH.
  - ovf<=ovf_pend; go to IDLE.
- Output timing (all outputs are registered):
  - busy=1 exactly during the W SHIFT cycles.
  - done=1 during the DONE cycle.
  - The new digit and ovf values are visible in the same cycle as done and hold until the next DONE or reset.
- Latency: with start sampled at edge E0, busy is high for cycles E0+1..E0+W. done is high in cycle E0+W+1. The next start is accepted at edge E0+W+2.
- start is ignored in SHIFT and DONE. It is not queued. Holding start high produces back-to-back conversions every W+2 cycles.
- value may change freely after capture; only the captured copy is used.
- With overflow inputs (10000..16383) bcd_sr wraps. This is harmless because the result is discarded in favour of dashes.
- With W<14, ovf can never assert.
- Digits never change between done pulses, so the display never shows a partial result.

Test Plan:
1. W=14, value=0, start pulse -> busy high for 14 cycles; done in cycle 15 after start; dig3..0=0,0,0,0; ovf=0.
2. value=1234 -> after done: dig3=1, dig2=2, dig1=3, dig0=4; ovf=0; busy low in the done cycle.
3. value=9999 then value=10000 (back-to-back, start held high) -> first done gives 9,9,9,9 with ovf=0; second done, 16 cycles later, gives 10,10,10,10 with ovf=1.
4. start asserted at value=42, then start pulsed again with value=7777 mid-SHIFT -> the second start is ignored; single done with 0,0,4,2; next idle start converts normally.
5. value=5678 started, reset asserted asynchronously at iteration 6 -> busy=0, done=0, digits=0 immediately; no done pulse afterwards; a fresh start with 5678 yields 5,6,7,8.
6. Randomised sweep 0..16383 against a reference model -> digits and ovf match for every value; done count equals start-accept count.
